// File: rtl/odo_sbox_prog.sv
// Programmable W-bit S-box with forward and inverse tables.
// Identity fill on reset or cfg_init; LANES lookups per beat.
module odo_sbox_prog #(
  parameter int W     = 6,
  parameter int LANES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [W-1:0]       cfg_addr,
  input  logic [W-1:0]       cfg_data,
  input  logic               cfg_init,
  output logic               cfg_ready,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [LANES*W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data
);

  localparam int DEPTH = 1 << W;
  localparam logic [W:0] C_LAST = (W+1)'(DEPTH - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t state_q, state_d;
  logic [W:0] c_q, c_d;
  logic out_valid_q, out_valid_d;
  logic [LANES*W-1:0] out_data_q, out_data_d;
  logic [LANES*W-1:0] look;

  logic [W-1:0] fwd_mem [DEPTH];
  logic [W-1:0] inv_mem [DEPTH];

  logic         tbl_we;
  logic [W-1:0] tbl_a;
  logic [W-1:0] tbl_d;
  logic         accept;

  assign busy      = (state_q == INIT);
  assign cfg_ready = (state_q == RUN);
  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next state, fill counter and the single table write port.
  // A write always pairs fwd[a]=d with inv[d]=a; the fill uses a=d=c.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    tbl_we  = 1'b0;
    tbl_a   = cfg_addr;
    tbl_d   = cfg_data;
    unique case (state_q)
      INIT: begin
        tbl_we = 1'b1;
        tbl_a  = c_q[W-1:0];
        tbl_d  = c_q[W-1:0];
        if (c_q == C_LAST) begin
          state_d = RUN;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      RUN: begin
        if (cfg_init) begin
          state_d = INIT;
          c_d     = '0;
        end else if (cfg_we) begin
          tbl_we = 1'b1;
        end
      end
      default: begin
        state_d = INIT;
        c_d     = '0;
      end
    endcase
  end

  // Per-lane table read; sees pre-write contents in a write cycle.
  always_comb begin
    look = '0;
    for (int k = 0; k < LANES; k++) begin
      if (in_inv) begin
        look[k*W +: W] = inv_mem[in_data[k*W +: W]];
      end else begin
        look[k*W +: W] = fwd_mem[in_data[k*W +: W]];
      end
    end
  end

  // Output register: load on accept, clear on drain, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = look;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and output state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Table storage, contents defined by the fill rather than reset.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      fwd_mem[tbl_a] <= tbl_d;
      inv_mem[tbl_d] <= tbl_a;
    end
  end

endmodule

// File: doc/odo_sbox_prog.md
ODO_SBOX_PROG -- requirements
Module: odo_sbox_prog

Interface
REQ-001 SHALL have parameter W, default 6, S-box input/output width in bits; table depth is 2^W.
REQ-002 SHALL have parameter LANES, default 2, number of parallel lookups per accepted beat.
REQ-003 SHALL have ports:
  clk  input  1  single clock; all logic on rising edge
  rst  input  1  asynchronous, active-high reset
  cfg_we  input  1  table write strobe
  cfg_addr  input  W  forward-table index to write
  cfg_data  input  W  value to store at cfg_addr
  cfg_init  input  1  pulse: refill table with identity map
  cfg_ready  output  1  table writes/init accepted this cycle
  busy  output  1  identity fill in progress
  in_valid  input  1  lookup request valid
  in_ready  output  1  lookup request accepted when high with in_valid
  in_inv  input  1  0 = forward lookup, 1 = inverse lookup
  in_data  input  LANES*W  lane k at bits [k*W +: W]
  out_valid  output  1  result valid
  out_ready  input  1  downstream accepts result
  out_data  output  LANES*W  lane k result at bits [k*W +: W]

Function
REQ-004 SHALL hold a forward table fwd[0..2^W-1] and an inverse table inv[0..2^W-1], each W bits wide.
REQ-005 SHALL implement FSM states INIT and RUN; INIT fills tables, RUN serves lookups and writes.
REQ-006 In INIT: counter c from 0 to 2^W-1, one per cycle, writes fwd[c]=c and inv[c]=c; after writing c=2^W-1, next state RUN; counter width W+1, no wrap.
REQ-007 busy SHALL be 1 exactly while state is INIT; cfg_ready SHALL be 1 exactly while state is RUN.
REQ-008 In RUN, cfg_we=1 SHALL write fwd[cfg_addr]=cfg_data and inv[cfg_data]=cfg_addr at that clock edge.
REQ-009 Inverse lookups SHALL be defined only while fwd is a permutation; otherwise inverse results are don't-care, but no other behaviour changes.
REQ-010 cfg_init=1 in RUN SHALL enter INIT with c=0 next cycle; cfg_init has priority over a simultaneous cfg_we, which is discarded; cfg_init and cfg_we in INIT SHALL be ignored.
REQ-011 in_ready SHALL equal (state==RUN) and (out_valid==0 or out_ready==1).
REQ-012 On accept (in_valid and in_ready) at edge t, out_data lane k SHALL be fwd[in lane k] (in_inv=0) or inv[in lane k] (in_inv=1), registered, with out_valid=1 from edge t; latency 1 cycle.
REQ-013 Lookup and write in the same cycle, including to the same entry, SHALL return the pre-write value; the next lookup sees the new value.
REQ-014 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-015 out_valid SHALL clear on an edge with out_ready=1 and no new accept; accept and drain in the same cycle SHALL keep out_valid=1 with new data (full throughput).
REQ-016 Entering INIT via cfg_init SHALL NOT disturb a pending output; it drains normally by out_ready.
REQ-017 All LANES SHALL be looked up independently in the same cycle; identical lane inputs SHALL return identical results.

Reset
REQ-018 rst=1 SHALL immediately force state=INIT, c=0, out_valid=0, out_data=0, busy=1, cfg_ready=0, in_ready=0.
REQ-019 Table contents SHALL NOT be reset asynchronously; the INIT fill after rst deassertion defines them.
REQ-020 rst asserted mid-INIT or mid-RUN SHALL restart the full fill from c=0 and drop any pending output.
REQ-021 After rst falls, busy SHALL stay 1 for exactly 2^W clock edges, then in_ready=1 (if out empty).

Verification (W=6, LANES=2)
REQ-022 Reset then release: busy=1 for 64 edges, then cfg_ready=1, in_ready=1; forward lookup {6'h05,6'h3f} -> out_data {6'h05,6'h3f} one cycle later.
REQ-023 Write fwd[0]=6'h17, fwd[1]=6'h10, fwd[0x17]=6'h00, fwd[0x10]=6'h01; forward {00,01} -> {17,10}; inverse {17,10} -> {00,01}.
REQ-024 Hold out_ready=0 after a result: out_data constant, in_ready=0 for 5 cycles; raise out_ready with in_valid=1: back-to-back results each cycle.
REQ-025 Same-cycle write fwd[3]=6'h2a and lookup {03,03}: returns {03,03}; next lookup {03,03} returns {2a,2a}.
REQ-026 Assert rst when c=20: busy restarts, 64 more edges after release; pulse cfg_init in RUN after writes: busy 64 edges, table identity again, held output still delivered.
